// File: rtl/mem_load_ctrl.sv
// Byte-stream loader: takes bytes from a valid/ready source and writes them to
// the banked word memory one byte address at a time, padding a trailing half word.
module mem_load_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  PAD_VALUE      = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] base_addr,
    input  logic [15:0] byte_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] bytes_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_PAD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [15:0] ptr;
    logic [15:0] rem;
    logic [15:0] to_cnt;
    logic [3:0]  hold_cnt;

    // Source handshake: a byte transfers on any edge where in_valid & in_ready.
    // in_ready depends only on state so the source never sees a combinational loop.
    assign in_ready = (state == S_WAIT);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            rem        <= '0;
            to_cnt     <= '0;
            hold_cnt   <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_wr     <= 1'b0;
            err        <= 1'b0;
            bytes_done <= '0;
        end else if (abort) begin
            state  <= S_IDLE;
            mem_wr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bytes_done <= '0;
                        err        <= 1'b0;
                        if (byte_count != 16'd0) begin
                            ptr    <= base_addr;
                            rem    <= byte_count;
                            to_cnt <= '0;
                            state  <= S_WAIT;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        mem_addr <= ptr;
                        mem_data <= in_data;
                        mem_wr   <= 1'b1;
                        hold_cnt <= '0;
                        to_cnt   <= '0;
                        state    <= S_HOLD;
                    end else if (TO_EN) begin
                        if (to_cnt == TO_LAST) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            to_cnt <= to_cnt + 16'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        mem_wr     <= 1'b0;
                        ptr        <= ptr + 16'd1;
                        rem        <= rem - 16'd1;
                        bytes_done <= bytes_done + 16'd1;
                        // A final byte on an even address leaves the high half of its word unwritten.
                        if (rem == 16'd1) begin
                            state <= ptr[0] ? S_DONE : S_PAD;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                S_PAD: begin
                    // First PAD cycle is a setup gap, mirroring the WAIT cycle between real bytes.
                    if (!mem_wr) begin
                        mem_addr <= ptr;
                        mem_data <= PAD_VALUE;
                        mem_wr   <= 1'b1;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        mem_wr <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_load_ctrl.md
Name: mem_load_ctrl

Overview:
Sequencer that streams bytes from a valid/ready source (UART or host bridge) into the four-bank 16-bit word memory. It generates the byte address, the byte data and a write strobe, holding each byte long enough for the memory's low/high byte assembler to capture it. It pads odd-length transfers to a whole word, detects source stalls with a timeout, and reports progress, completion and error status to the top-level control FSM.

Parameters:
HOLD_CYCLES, 2, cycles mem_wr/mem_addr/mem_data are held per byte (legal range 1..15)
TIMEOUT_CYCLES, 65535, maximum idle cycles waiting for a byte in WAIT_BYTE; 0 disables the timeout
PAD_VALUE, 8'h00, byte written to complete a trailing half word

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a transfer; ignored unless in IDLE
abort  input  1  forces return to IDLE from any state
base_addr  input  16  byte address of the first byte, sampled on accepted start
byte_count  input  16  number of source bytes, sampled on accepted start
in_valid  input  1  source byte valid
in_data  input  8  source byte
in_ready  output  1  controller accepts a byte this cycle
mem_addr  output  16  byte address to memory
mem_data  output  8  byte data to memory
mem_wr  output  1  write strobe; high during HOLD
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  sticky timeout flag
bytes_done  output  16  source bytes committed in current or last transfer

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, internal pointer, remaining count and timeout counter cleared.
- States: IDLE, WAIT_BYTE, HOLD, PAD, DONE.
- IDLE:
  - start=1 with byte_count!=0: latch ptr=base_addr and rem=byte_count, clear bytes_done and err, go to WAIT_BYTE.
  - start=1 with byte_count=0: clear bytes_done and err, go to DONE (done pulse, no writes).
- WAIT_BYTE:
  - in_ready=1 (combinational from state). Timeout counter increments each cycle without a handshake.
  - Handshake (in_valid & in_ready) at edge N: mem_addr<=ptr, mem_data<=in_data, mem_wr<=1, go to HOLD, reset timeout counter.
  - mem_wr is high for exactly HOLD_CYCLES cycles, starting the cycle after edge N.
- HOLD:
  - in_ready=0, outputs stable.
  - On the last hold cycle: mem_wr<=0, ptr<=ptr+1 (0xFFFF wraps to 0x0000), rem<=rem-1, bytes_done<=bytes_done+1.
  - If rem becomes 0: go to PAD when the committed address was even (low byte only), otherwise go to DONE.
  - If rem!=0: go to WAIT_BYTE.
- PAD:
  - Drive mem_addr=ptr (odd address) and mem_data=PAD_VALUE, with mem_wr high for HOLD_CYCLES cycles; then go to DONE.
  - The pad byte does not count in bytes_done. in_ready=0.
- DONE: done=1 for exactly one cycle, then go to IDLE (busy=0 in that next cycle).
- Timeout: in WAIT_BYTE with TIMEOUT_CYCLES!=0, if the counter reaches TIMEOUT_CYCLES, set err=1 and go to IDLE. No done pulse, no pad.
- abort:
  - Has priority over every other event, including a handshake in the same cycle; that byte is not accepted.
  - Next state is IDLE; mem_wr drops to 0 that edge; no done.
  - bytes_done and err keep their values.
- start while busy is ignored.
- start and abort in the same cycle in IDLE: abort wins.
- mem_addr and mem_data hold their last values in IDLE.
- Reset asserted mid-transfer: immediate return to reset values; the partial word in memory is left as is.
- Throughput: one byte per HOLD_CYCLES+1 cycles when the source is always valid.

Test Plan:
- Basic: base=0x0000, count=4, bytes 11,22,33,44 always valid, HOLD_CYCLES=2 -> mem_wr pulses of 2 cycles at addresses 0,1,2,3; in_ready high one cycle per 3; done one cycle after the last hold; bytes_done=4; no pad.
- Odd length: base=0x4000, count=3 -> writes at 4000, 4001, 4002, then pad 8'h00 at 4003; bytes_done=3; done after the pad.
- Wrap: base=0xFFFE, count=4 -> addresses FFFE, FFFF, 0000, 0001; done asserted, no err.
- Timeout: TIMEOUT_CYCLES=8, count=2, one byte then in_valid=0 -> err=1 and busy=0 after 8 idle cycles; bytes_done=1; done never pulses.
- Abort and restart: abort during the second byte's HOLD -> mem_wr low next cycle, IDLE, bytes_done=1; a new start with count=0 -> done pulse the next cycle, err=0, bytes_done=0.
- Reset mid-transfer: rst low during HOLD -> all outputs 0 asynchronously; start after rst high behaves as a fresh transfer.
